cheri_tag_arbiter: RTL and testbench
====================================

Name: cheri_tag_arbiter

Overview:
- Schedules the single-port CHERI capability-tag SRAM that shadows the data cache; one tag bit per CLEN-bit capability slot.
- Shares the port between three requesters: store tag updates, dcache refill tag reads and the revocation sweeper's tag reads.
- After reset, runs a sequenced clear of the whole tag array before granting any requester.
- Sits beside the dcache, between the load/store unit and the tag SRAM macro.

Parameters:
- NumLines, 256: tag SRAM depth, one row per dcache line; must be a power of two.
- TagsPerLine, 4: tags per row (DCACHE_LINE_WIDTH/CLEN).
- SweepMaxWait, 15: cycles a sweep request may be refused before it is promoted to top priority.
- IdxW, $clog2(NumLines): derived row address width.
- OffW, max(1,$clog2(TagsPerLine)): derived slot offset width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- init_done_o  out  1  tag array cleared; arbitration live
- st_req_i  in  1  store tag write request
- st_gnt_o  out  1  store write accepted this cycle
- st_idx_i  in  IdxW  store row
- st_off_i  in  OffW  slot within row
- st_tag_i  in  1  tag value to write
- rf_req_i  in  1  refill tag read request
- rf_gnt_o  out  1  refill read accepted
- rf_idx_i  in  IdxW  refill row
- rf_rvalid_o  out  1  refill tags valid
- rf_rtags_o  out  TagsPerLine  refill row tags
- sw_req_i  in  1  sweep tag read request
- sw_gnt_o  out  1  sweep read accepted
- sw_idx_i  in  IdxW  sweep row
- sw_rvalid_o  out  1  sweep tags valid
- sw_rtags_o  out  TagsPerLine  sweep row tags
- sram_req_o  out  1  SRAM access
- sram_we_o  out  1  write enable
- sram_addr_o  out  IdxW  row address
- sram_wmask_o  out  TagsPerLine  per-bit write mask
- sram_wdata_o  out  TagsPerLine  write data
- sram_rdata_i  in  TagsPerLine  read data, one cycle after read request

Behaviour:
- Reset values:
  - FSM = INIT, init counter = 0.
  - init_done_o = 0.
  - All gnt and rvalid outputs = 0.
  - Sweep wait counter = 0.
- INIT state:
  - Each cycle drives sram_req_o=1, sram_we_o=1, wmask all ones, wdata=0, addr = counter; counter increments.
  - After the write to row NumLines-1, moves to RUN on the next edge; init takes exactly NumLines cycles.
  - No grants are given in INIT; requests are held off and not lost.
- RUN state: at most one grant per cycle. Grants are combinational from the requests and the current state.
  - Normal priority: store > refill > sweep.
  - Aged priority: when the sweep wait counter equals SweepMaxWait and sw_req_i=1, sweep > store > refill.
- Sweep wait counter:
  - Increments on each cycle with sw_req_i=1 and sw_gnt_o=0, saturating at SweepMaxWait.
  - Clears on sw_gnt_o=1 or when sw_req_i=0.
- Store grant drives:
  - sram_we_o=1, addr=st_idx_i.
  - wmask = one-hot(st_off_i).
  - wdata = st_tag_i replicated across the row; only the masked bit is written.
- Read grants drive sram_we_o=0 and addr = the requester's index.
- Read response:
  - A registered owner flag (rf/sw) plus a valid bit produce rf_rvalid_o or sw_rvalid_o exactly one cycle after the grant.
  - rtags outputs carry sram_rdata_i directly.
  - Responses are in order and cannot be back-pressured.
- Same-row hazard: a store granted in cycle N and a read of the same row granted in N+1 returns the post-store value (SRAM write-first ordering is not required, because accesses never overlap).
- sram_req_o=0 when no grant and not in INIT.
- Reset asserted mid-INIT or mid-RUN:
  - Returns to INIT at counter 0 and restarts the clear.
  - Any in-flight rvalid is dropped: no response appears in the cycle after reset.

Optional Feature:
- Macro: CHERI_TAG_ARB_PERF_EN.
- When defined, adds three 32-bit outputs: perf_st_conflict_o, perf_rf_stall_o, perf_sw_promote_o.
  - perf_st_conflict_o counts cycles with st_req_i=1 and st_gnt_o=0.
  - perf_rf_stall_o counts cycles with rf_req_i=1 and rf_gnt_o=0.
  - perf_sw_promote_o counts aged sweep grants.
  - All three are zero in reset and INIT; they wrap on overflow.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package cheri_tag_pkg holds:
  - requester enum tag_req_e {TagReqStore, TagReqRefill, TagReqSweep}
  - FSM enum tag_arb_state_e {TagArbInit, TagArbRun}
  - struct tag_sram_req_t {req, we, addr, wmask, wdata}
- Natural sub-module: cheri_tag_prio_sel, the combinational 3-way priority selector with an aged-override input.
- The FSM, counters and response pipeline stay in cheri_tag_arbiter.

Test Plan:
- Reset, then hold all requests for 256 cycles:
  - 256 consecutive writes to rows 0..255 with wdata=0.
  - init_done_o rises in cycle 257.
  - A refill read of row 5 returns 4'b0000.
- Store idx=5, off=2, tag=1, then refill read of row 5 in the next cycle:
  - wmask=4'b0100.
  - rf_rvalid_o one cycle after rf_gnt_o, rf_rtags_o=4'b0100.
- st_req_i, rf_req_i and sw_req_i all held high on different rows:
  - Store granted every cycle.
  - Sweep granted in the cycle after 15 refusals.
  - Refill never granted while the store is held.
- Store and refill simultaneous on row 9:
  - Store granted first; refill granted next cycle and sees the stored bit.
- Assert rst_i for one cycle while at RUN with a read in flight:
  - No rvalid the following cycle.
  - INIT restarts at row 0; init_done_o=0.
- With CHERI_TAG_ARB_PERF_EN defined, hold st_req_i and sw_req_i together for 20 cycles:
  - perf_sw_promote_o=1.
  - perf_st_conflict_o=1.

Source files
------------

// File: rtl/cheri_tag_arbiter_pkg.sv
// Shared types for the CHERI capability-tag SRAM arbiter: requester ids, FSM states,
// the SRAM command bundle and the slot write-mask helper.
package cheri_tag_pkg;

  localparam int unsigned TagDefNumLines = 256;
  localparam int unsigned TagDefPerLine  = 4;
  localparam int unsigned TagDefIdxW     = $clog2(TagDefNumLines);
  localparam int unsigned TagDefOffW     = (TagDefPerLine > 1) ? $clog2(TagDefPerLine) : 1;

  typedef enum logic [1:0] {
    TagReqStore,
    TagReqRefill,
    TagReqSweep
  } tag_req_e;

  typedef enum logic {
    TagArbInit,
    TagArbRun
  } tag_arb_state_e;

  typedef struct packed {
    logic                     req;
    logic                     we;
    logic [TagDefIdxW-1:0]    addr;
    logic [TagDefPerLine-1:0] wmask;
    logic [TagDefPerLine-1:0] wdata;
  } tag_sram_req_t;

  // Write mask selecting the single tag slot addressed by a store.
  function automatic logic [TagDefPerLine-1:0] tag_onehot(input logic [TagDefOffW-1:0] off);
    logic [TagDefPerLine-1:0] mask;
    mask      = '0;
    mask[off] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/cheri_tag_arbiter_if.sv
// Requester, response and SRAM-port signals of the tag arbiter.
// Perf counter outputs exist only when CHERI_TAG_ARB_PERF_EN is defined.
interface cheri_tag_arbiter_if #(
  parameter int unsigned NumLines    = 256,
  parameter int unsigned TagsPerLine = 4
);
  localparam int unsigned IdxW = $clog2(NumLines);
  localparam int unsigned OffW = (TagsPerLine > 1) ? $clog2(TagsPerLine) : 1;

  logic                   init_done_o;
  logic                   st_req_i;
  logic                   st_gnt_o;
  logic [IdxW-1:0]        st_idx_i;
  logic [OffW-1:0]        st_off_i;
  logic                   st_tag_i;
  logic                   rf_req_i;
  logic                   rf_gnt_o;
  logic [IdxW-1:0]        rf_idx_i;
  logic                   rf_rvalid_o;
  logic [TagsPerLine-1:0] rf_rtags_o;
  logic                   sw_req_i;
  logic                   sw_gnt_o;
  logic [IdxW-1:0]        sw_idx_i;
  logic                   sw_rvalid_o;
  logic [TagsPerLine-1:0] sw_rtags_o;
  logic                   sram_req_o;
  logic                   sram_we_o;
  logic [IdxW-1:0]        sram_addr_o;
  logic [TagsPerLine-1:0] sram_wmask_o;
  logic [TagsPerLine-1:0] sram_wdata_o;
  logic [TagsPerLine-1:0] sram_rdata_i;
`ifdef CHERI_TAG_ARB_PERF_EN
  logic [31:0]            perf_st_conflict_o;
  logic [31:0]            perf_rf_stall_o;
  logic [31:0]            perf_sw_promote_o;
`endif

  modport slave (
`ifdef CHERI_TAG_ARB_PERF_EN
    output perf_st_conflict_o, perf_rf_stall_o, perf_sw_promote_o,
`endif
    input  st_req_i, st_idx_i, st_off_i, st_tag_i, rf_req_i, rf_idx_i,
    input  sw_req_i, sw_idx_i, sram_rdata_i,
    output init_done_o, st_gnt_o, rf_gnt_o, rf_rvalid_o, rf_rtags_o,
    output sw_gnt_o, sw_rvalid_o, sw_rtags_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wmask_o, sram_wdata_o
  );

  modport master (
`ifdef CHERI_TAG_ARB_PERF_EN
    input  perf_st_conflict_o, perf_rf_stall_o, perf_sw_promote_o,
`endif
    output st_req_i, st_idx_i, st_off_i, st_tag_i, rf_req_i, rf_idx_i,
    output sw_req_i, sw_idx_i, sram_rdata_i,
    input  init_done_o, st_gnt_o, rf_gnt_o, rf_rvalid_o, rf_rtags_o,
    input  sw_gnt_o, sw_rvalid_o, sw_rtags_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wmask_o, sram_wdata_o
  );

endinterface

// File: rtl/cheri_tag_arbiter_prio_sel.sv
// Three-way one-hot priority selector for the tag SRAM port.
// Normal order store > refill > sweep; an aged sweep jumps to the front.
module cheri_tag_prio_sel (
  input  logic en,
  input  logic aged,
  input  logic st_req,
  input  logic rf_req,
  input  logic sw_req,
  output logic st_gnt,
  output logic rf_gnt,
  output logic sw_gnt
);

  always_comb begin
    st_gnt = 1'b0;
    rf_gnt = 1'b0;
    sw_gnt = 1'b0;
    if (en) begin
      if (aged && sw_req) begin
        sw_gnt = 1'b1;
      end else if (st_req) begin
        st_gnt = 1'b1;
      end else if (rf_req) begin
        rf_gnt = 1'b1;
      end else if (sw_req) begin
        sw_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cheri_tag_arbiter.sv
// Single-port CHERI tag SRAM arbiter: clears the array after reset, then shares the
// port between store, refill and sweep. Optional perf counters: CHERI_TAG_ARB_PERF_EN.
//
// state      | meaning
// TagArbInit | writing zeros to row init_cnt_q, no grants
// TagArbRun  | arbitration live, one grant per cycle
module cheri_tag_arbiter
  import cheri_tag_pkg::*;
#(
  parameter int unsigned NumLines     = TagDefNumLines,
  parameter int unsigned TagsPerLine  = TagDefPerLine,
  parameter int unsigned SweepMaxWait = 15,
  parameter int unsigned IdxW         = $clog2(NumLines),
  parameter int unsigned OffW         = (TagsPerLine > 1) ? $clog2(TagsPerLine) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cheri_tag_arbiter_if.slave  bus
);

  localparam int unsigned WaitW = $clog2(SweepMaxWait + 1);

  tag_arb_state_e state_q, state_d;
  logic [IdxW-1:0]  init_cnt_q;
  logic [WaitW-1:0] sw_wait_q;
  logic             rd_valid_q;
  tag_req_e         rd_owner_q;
  logic             run, aged;
  logic             st_gnt, rf_gnt, sw_gnt;
  tag_sram_req_t    sram_cmd;

  assign run  = (state_q == TagArbRun);
  assign aged = bus.sw_req_i && (sw_wait_q == WaitW'(SweepMaxWait));

  cheri_tag_prio_sel u_prio_sel (
    .en     (run),
    .aged   (aged),
    .st_req (bus.st_req_i),
    .rf_req (bus.rf_req_i),
    .sw_req (bus.sw_req_i),
    .st_gnt (st_gnt),
    .rf_gnt (rf_gnt),
    .sw_gnt (sw_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= TagArbInit;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!run) init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TagArbInit: if (init_cnt_q == IdxW'(NumLines - 1)) state_d = TagArbRun;
      TagArbRun:  state_d = TagArbRun;
      default:    state_d = TagArbInit;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_wait_q <= '0;
    end else if (!bus.sw_req_i || sw_gnt) begin
      sw_wait_q <= '0;
    end else if (sw_wait_q != WaitW'(SweepMaxWait)) begin
      sw_wait_q <= sw_wait_q + 1'b1;
    end
  end

  // Accesses never overlap, so a read granted right after a store sees the new bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= TagReqRefill;
    end else begin
      rd_valid_q <= rf_gnt || sw_gnt;
      rd_owner_q <= sw_gnt ? TagReqSweep : TagReqRefill;
    end
  end

  always_comb begin
    sram_cmd = '0;
    if (!run) begin
      sram_cmd.req   = 1'b1;
      sram_cmd.we    = 1'b1;
      sram_cmd.addr  = init_cnt_q;
      sram_cmd.wmask = '1;
    end else if (st_gnt) begin
      sram_cmd.req   = 1'b1;
      sram_cmd.we    = 1'b1;
      sram_cmd.addr  = bus.st_idx_i;
      sram_cmd.wmask = tag_onehot(bus.st_off_i);
      sram_cmd.wdata = {TagsPerLine{bus.st_tag_i}};
    end else if (rf_gnt) begin
      sram_cmd.req   = 1'b1;
      sram_cmd.addr  = bus.rf_idx_i;
    end else if (sw_gnt) begin
      sram_cmd.req   = 1'b1;
      sram_cmd.addr  = bus.sw_idx_i;
    end
  end

  assign bus.init_done_o  = run;
  assign bus.st_gnt_o     = st_gnt;
  assign bus.rf_gnt_o     = rf_gnt;
  assign bus.sw_gnt_o     = sw_gnt;
  assign bus.rf_rvalid_o  = rd_valid_q && (rd_owner_q == TagReqRefill);
  assign bus.sw_rvalid_o  = rd_valid_q && (rd_owner_q == TagReqSweep);
  assign bus.rf_rtags_o   = bus.sram_rdata_i;
  assign bus.sw_rtags_o   = bus.sram_rdata_i;
  assign bus.sram_req_o   = sram_cmd.req;
  assign bus.sram_we_o    = sram_cmd.we;
  assign bus.sram_addr_o  = sram_cmd.addr;
  assign bus.sram_wmask_o = sram_cmd.wmask;
  assign bus.sram_wdata_o = sram_cmd.wdata;

`ifdef CHERI_TAG_ARB_PERF_EN
  logic [31:0] perf_st_conflict_q, perf_rf_stall_q, perf_sw_promote_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_st_conflict_q <= '0;
      perf_rf_stall_q    <= '0;
      perf_sw_promote_q  <= '0;
    end else if (run) begin
      if (bus.st_req_i && !st_gnt) perf_st_conflict_q <= perf_st_conflict_q + 32'd1;
      if (bus.rf_req_i && !rf_gnt) perf_rf_stall_q    <= perf_rf_stall_q + 32'd1;
      if (aged && sw_gnt)          perf_sw_promote_q  <= perf_sw_promote_q + 32'd1;
    end
  end

  assign bus.perf_st_conflict_o = perf_st_conflict_q;
  assign bus.perf_rf_stall_o    = perf_rf_stall_q;
  assign bus.perf_sw_promote_o  = perf_sw_promote_q;
`endif

endmodule

// File: tb/tb_cheri_tag_arbiter.sv
// Directed self-checking bench for cheri_tag_arbiter with a behavioural tag SRAM.
// Perf counter scenario is compiled in when CHERI_TAG_ARB_PERF_EN is defined.
module tb_cheri_tag_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cheri_tag_arbiter_if #(.NumLines(256), .TagsPerLine(4)) bus ();

  cheri_tag_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [256];
  logic [3:0] rdata_q = 4'h0;
  assign bus.sram_rdata_i = rdata_q;

  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_we_o)
        mem[bus.sram_addr_o] <= (mem[bus.sram_addr_o] & ~bus.sram_wmask_o) |
                                (bus.sram_wdata_o & bus.sram_wmask_o);
      else
        rdata_q <= mem[bus.sram_addr_o];
    end
  end

  task automatic idle();
    bus.st_req_i = 1'b0; bus.st_idx_i = '0; bus.st_off_i = '0; bus.st_tag_i = 1'b0;
    bus.rf_req_i = 1'b0; bus.rf_idx_i = '0;
    bus.sw_req_i = 1'b0; bus.sw_idx_i = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.rf_req_i = 1'b1; bus.rf_idx_i = 8'd5;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.init_done_o !== 1'b0 || bus.st_gnt_o !== 1'b0 || bus.rf_gnt_o !== 1'b0 ||
        bus.sw_gnt_o !== 1'b0 || bus.rf_rvalid_o !== 1'b0 || bus.sw_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got done=%b gnt=%b%b%b rv=%b%b exp all 0", bus.init_done_o,
               bus.st_gnt_o, bus.rf_gnt_o, bus.sw_gnt_o, bus.rf_rvalid_o, bus.sw_rvalid_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_clear();
    for (int k = 0; k < 256; k++) begin
      #1;
      total++;
      if (bus.sram_req_o !== 1'b1 || bus.sram_we_o !== 1'b1 || bus.sram_addr_o !== 8'(k) ||
          bus.sram_wmask_o !== 4'hF || bus.sram_wdata_o !== 4'h0 ||
          bus.init_done_o !== 1'b0 || bus.rf_gnt_o !== 1'b0) begin
        bad++;
        $display("FAIL init_row got req=%b we=%b addr=%0d mask=%h data=%h done=%b gnt=%b exp row %0d clear",
                 bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wmask_o,
                 bus.sram_wdata_o, bus.init_done_o, bus.rf_gnt_o, k);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (bus.init_done_o !== 1'b1 || bus.rf_gnt_o !== 1'b1 || bus.sram_we_o !== 1'b0 ||
        bus.sram_addr_o !== 8'd5) begin
      bad++;
      $display("FAIL init_done got done=%b rf_gnt=%b we=%b addr=%0d exp 1 1 0 5",
               bus.init_done_o, bus.rf_gnt_o, bus.sram_we_o, bus.sram_addr_o);
    end
    @(negedge clk);
    bus.rf_req_i = 1'b0;
    #1;
    total++;
    if (bus.rf_rvalid_o !== 1'b1 || bus.rf_rtags_o !== 4'b0000 || bus.sw_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL init_read got rv=%b tags=%b swrv=%b exp 1 0000 0",
               bus.rf_rvalid_o, bus.rf_rtags_o, bus.sw_rvalid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_store_then_read();
    idle();
    bus.st_req_i = 1'b1; bus.st_idx_i = 8'd5; bus.st_off_i = 2'd2; bus.st_tag_i = 1'b1;
    #1;
    total++;
    if (bus.st_gnt_o !== 1'b1 || bus.sram_we_o !== 1'b1 || bus.sram_addr_o !== 8'd5 ||
        bus.sram_wmask_o !== 4'b0100 || bus.sram_wdata_o !== 4'b1111) begin
      bad++;
      $display("FAIL store_cmd got gnt=%b we=%b addr=%0d mask=%b data=%b exp 1 1 5 0100 1111",
               bus.st_gnt_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wmask_o, bus.sram_wdata_o);
    end
    @(negedge clk);
    idle();
    bus.rf_req_i = 1'b1; bus.rf_idx_i = 8'd5;
    #1;
    total++;
    if (bus.rf_gnt_o !== 1'b1 || bus.sram_we_o !== 1'b0 || bus.sram_addr_o !== 8'd5 ||
        bus.rf_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL refill_cmd got gnt=%b we=%b addr=%0d rv=%b exp 1 0 5 0",
               bus.rf_gnt_o, bus.sram_we_o, bus.sram_addr_o, bus.rf_rvalid_o);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (bus.rf_rvalid_o !== 1'b1 || bus.rf_rtags_o !== 4'b0100 || bus.sram_req_o !== 1'b0) begin
      bad++;
      $display("FAIL refill_resp got rv=%b tags=%b req=%b exp 1 0100 0",
               bus.rf_rvalid_o, bus.rf_rtags_o, bus.sram_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_three_way();
    bit exp_sw;
    idle();
    bus.st_req_i = 1'b1; bus.st_idx_i = 8'd10; bus.st_off_i = 2'd1; bus.st_tag_i = 1'b1;
    bus.rf_req_i = 1'b1; bus.rf_idx_i = 8'd20;
    bus.sw_req_i = 1'b1; bus.sw_idx_i = 8'd30;
    for (int i = 0; i < 32; i++) begin
      #1;
      exp_sw = (i == 15) || (i == 31);
      total++;
      if (bus.st_gnt_o !== !exp_sw || bus.sw_gnt_o !== exp_sw || bus.rf_gnt_o !== 1'b0 ||
          bus.sw_rvalid_o !== (i == 16) || bus.rf_rvalid_o !== 1'b0) begin
        bad++;
        $display("FAIL three_way cycle %0d got st=%b rf=%b sw=%b swrv=%b rfrv=%b exp st=%b rf=0 sw=%b swrv=%b rfrv=0",
                 i, bus.st_gnt_o, bus.rf_gnt_o, bus.sw_gnt_o, bus.sw_rvalid_o, bus.rf_rvalid_o,
                 !exp_sw, exp_sw, (i == 16));
      end
      total++;
      if (exp_sw ? (bus.sram_we_o !== 1'b0 || bus.sram_addr_o !== 8'd30)
                 : (bus.sram_we_o !== 1'b1 || bus.sram_addr_o !== 8'd10 || bus.sram_wmask_o !== 4'b0010)) begin
        bad++;
        $display("FAIL three_way_cmd cycle %0d got we=%b addr=%0d mask=%b", i,
                 bus.sram_we_o, bus.sram_addr_o, bus.sram_wmask_o);
      end
      @(negedge clk);
    end
    idle();
    #1;
    total++;
    if (bus.sw_rvalid_o !== 1'b1 || bus.sw_rtags_o !== 4'b0000 || bus.rf_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL sweep_resp got rv=%b tags=%b rfrv=%b exp 1 0000 0",
               bus.sw_rvalid_o, bus.sw_rtags_o, bus.rf_rvalid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_same_row();
    idle();
    bus.st_req_i = 1'b1; bus.st_idx_i = 8'd9; bus.st_off_i = 2'd3; bus.st_tag_i = 1'b1;
    bus.rf_req_i = 1'b1; bus.rf_idx_i = 8'd9;
    #1;
    total++;
    if (bus.st_gnt_o !== 1'b1 || bus.rf_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL same_row_first got st=%b rf=%b exp 1 0", bus.st_gnt_o, bus.rf_gnt_o);
    end
    @(negedge clk);
    bus.st_req_i = 1'b0;
    #1;
    total++;
    if (bus.rf_gnt_o !== 1'b1 || bus.sram_addr_o !== 8'd9) begin
      bad++;
      $display("FAIL same_row_second got rf=%b addr=%0d exp 1 9", bus.rf_gnt_o, bus.sram_addr_o);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (bus.rf_rvalid_o !== 1'b1 || bus.rf_rtags_o !== 4'b1000) begin
      bad++;
      $display("FAIL same_row_resp got rv=%b tags=%b exp 1 1000", bus.rf_rvalid_o, bus.rf_rtags_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int cnt;
    idle();
    bus.rf_req_i = 1'b1; bus.rf_idx_i = 8'd5;
    rst = 1'b1;
    #1;
    total++;
    if (bus.rf_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL midrun_grant got rf_gnt=%b exp 1", bus.rf_gnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    total++;
    if (bus.rf_rvalid_o !== 1'b0 || bus.sw_rvalid_o !== 1'b0 || bus.init_done_o !== 1'b0 ||
        bus.sram_addr_o !== 8'd0 || bus.sram_we_o !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset got rv=%b%b done=%b addr=%0d we=%b exp 00 0 0 1",
               bus.rf_rvalid_o, bus.sw_rvalid_o, bus.init_done_o, bus.sram_addr_o, bus.sram_we_o);
    end
    @(negedge clk);
    cnt = 1;
    #1;
    total++;
    if (bus.sram_addr_o !== 8'd1 || bus.init_done_o !== 1'b0) begin
      bad++;
      $display("FAIL midrun_row1 got addr=%0d done=%b exp 1 0", bus.sram_addr_o, bus.init_done_o);
    end
    while (bus.init_done_o !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
      #1;
    end
    total++;
    if (cnt !== 256) begin
      bad++;
      $display("FAIL midrun_init_len got %0d cycles exp 256", cnt);
    end
  endtask

`ifdef CHERI_TAG_ARB_PERF_EN
  task automatic test_perf();
    total++;
    if (bus.perf_st_conflict_o !== 32'd0 || bus.perf_rf_stall_o !== 32'd0 ||
        bus.perf_sw_promote_o !== 32'd0) begin
      bad++;
      $display("FAIL perf_zero got %0d %0d %0d exp 0 0 0", bus.perf_st_conflict_o,
               bus.perf_rf_stall_o, bus.perf_sw_promote_o);
    end
    @(negedge clk);
    idle();
    bus.st_req_i = 1'b1; bus.st_idx_i = 8'd1;
    bus.sw_req_i = 1'b1; bus.sw_idx_i = 8'd2;
    repeat (20) @(negedge clk);
    idle();
    #1;
    total++;
    if (bus.perf_sw_promote_o !== 32'd1 || bus.perf_st_conflict_o !== 32'd1 ||
        bus.perf_rf_stall_o !== 32'd0) begin
      bad++;
      $display("FAIL perf_counts got promote=%0d conflict=%0d stall=%0d exp 1 1 0",
               bus.perf_sw_promote_o, bus.perf_st_conflict_o, bus.perf_rf_stall_o);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int r = 0; r < 256; r++) mem[r] = 4'hF;
    test_reset();
    test_init_clear();
    test_store_then_read();
    test_three_way();
    test_same_row();
    test_reset_midrun();
`ifdef CHERI_TAG_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
